// File: rtl/uart_pkg.sv
// Shared UART receive definitions: rx FSM state type, data width,
// and the clocks-per-bit helper. Optional macro: UART_RX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line.
// Ports: clk, rst (async, active high), async_in, sync_out.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Both flops reset high so an idle line never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with a
// one-entry valid/ready output buffer and error pulses.
// Ports: clk, rst (async, active high), uart_rx (serial in, idle high),
//   data_out/data_valid/data_ready (byte handshake),
//   frame_err, overrun, parity_err (1-cycle pulses), busy (frame active).
module uart_byte_rx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    import uart_pkg::*;

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 mid_bit;

    uart_sync2 u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (uart_rx),
        .sync_out (rx_s)
    );

    // After the half-bit start delay, every full bit period lands mid-bit.
    assign mid_bit = (cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Consumed byte; a same-cycle load below overrides this.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // Too short to be a start bit: silent drop.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (mid_bit) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_bit) begin
                        cnt     <= '0;
                        // Even parity: data bits plus parity bit XOR to 0.
                        par_bad <= rx_s ^ (^shreg);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (mid_bit) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
`endif
                        if (!rx_s) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (!par_bad) begin
`else
                        end else begin
`endif
                            if (!data_valid || data_ready) begin
                                data_out   <= shreg;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: byte table, corner sequences
// and randomized frames against a byte-queue reference model.
module tb_uart_byte_rx;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 115200;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    uart_byte_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side observation: accepted bytes and pulse counts.
    logic [7:0] rxq[$];
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;
    int   perr_cnt = 0;
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    logic dv_d     = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            dv_d <= 1'b0;
        end else begin
            if (frame_err)  ferr_cnt <= ferr_cnt + 1;
            if (overrun)    ovr_cnt  <= ovr_cnt + 1;
            if (parity_err) perr_cnt <= perr_cnt + 1;
            if (data_valid && !dv_d) begin
                rise_cnt <= rise_cnt + 1;
                rise_cyc <= cyc;
            end
            if (data_valid && data_ready) rxq.push_back(data_out);
            dv_d <= data_valid;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok,
                        input bit par_flip);
        uart_rx   = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        if (PB == 1) begin
            uart_rx = (^b) ^ par_flip;
            tick(CPB);
        end
        if (stop_ok) begin
            uart_rx = 1'b1;
            tick(CPB);
        end else begin
            // Low long enough to cover the mid-bit sample, then idle.
            uart_rx = 1'b0;
            tick(64);
            uart_rx = 1'b1;
            tick(CPB - 64);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_valid"}, data_valid, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_perr"}, parity_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_rx;
        int         exp_ferr;
    } vec_t;

    vec_t vt[6];

    initial begin
        int n0, f0, r0, o0, p0, lat, exp_ferr;
        bit fell, ok;
        logic [7:0] b;
        logic [7:0] expq[$];

        vt[0] = '{8'hA5, 1'b1, 1, 0};
        vt[1] = '{8'h00, 1'b1, 1, 0};
        vt[2] = '{8'hFF, 1'b1, 1, 0};
        vt[3] = '{8'h3C, 1'b0, 0, 1};
        vt[4] = '{8'h80, 1'b1, 1, 0};
        vt[5] = '{8'h01, 1'b1, 1, 0};

        rst        = 1'b0;
        uart_rx    = 1'b1;
        data_ready = 1'b1;
        #2 rst = 1'b1;
        tick(5);
        @(negedge clk);
        check_all_zero("reset");
        tick(1);
        rst = 1'b0;
        tick(5);

        // Byte table with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            n0 = rxq.size();
            f0 = ferr_cnt;
            r0 = rise_cnt;
            send(vt[i].data, vt[i].stop_ok, 1'b0);
            tick(20);
            @(negedge clk);
            check($sformatf("vec%0d_count", i), rxq.size() - n0, vt[i].exp_rx);
            check($sformatf("vec%0d_rise", i), rise_cnt - r0, vt[i].exp_rx);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vt[i].exp_ferr);
            if (vt[i].exp_rx == 1 && rxq.size() > n0) begin
                check($sformatf("vec%0d_data", i), rxq[$], vt[i].data);
                // Valid appears at the stop-bit middle plus sync delay.
                lat = rise_cyc - start_cyc;
                check($sformatf("vec%0d_latency_ok(lat=%0d)", i, lat),
                      int'(lat >= (CPB * 19) / 2 + PB * CPB - 4 &&
                           lat <= (CPB * 19) / 2 + PB * CPB + 8), 1);
            end
            tick(200);
        end
        check("no_overrun_while_ready", ovr_cnt, 0);
        check("no_parity_err_good_frames", perr_cnt, 0);

        // Short low glitch: START rejects it silently.
        r0 = rise_cnt;
        f0 = ferr_cnt;
        uart_rx = 1'b0;
        tick(30);
        uart_rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_high", busy, 1);
        fell = 1'b0;
        for (int i = 0; i < 25 && !fell; i++) begin
            @(negedge clk);
            if (!busy) fell = 1'b1;
        end
        check("glitch_busy_fall_55", fell, 1);
        tick(1200);
        check("glitch_no_valid", rise_cnt - r0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);

        // Two back-to-back bytes with the consumer stalled.
        tick(1);
        data_ready = 1'b0;
        o0 = ovr_cnt;
        n0 = rxq.size();
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        tick(20);
        @(negedge clk);
        check("ovr_data_kept", data_out, 8'h11);
        check("ovr_valid_held", data_valid, 1);
        check("ovr_pulse_once", ovr_cnt - o0, 1);
        check("ovr_nothing_taken", rxq.size() - n0, 0);
        tick(1);
        data_ready = 1'b1;
        tick(3);
        @(negedge clk);
        check("ovr_drain_count", rxq.size() - n0, 1);
        if (rxq.size() > n0) check("ovr_drain_data", rxq[$], 8'h11);
        check("ovr_valid_cleared", data_valid, 0);
        tick(200);

        // Reset in the middle of the 4th data bit of 0xFF.
        f0 = ferr_cnt;
        r0 = rise_cnt;
        uart_rx = 1'b0;
        tick(CPB);
        uart_rx = 1'b1;
        tick(3 * CPB + CPB / 2);
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        check_all_zero("midrst");
        tick(1);
        rst = 1'b0;
        tick(1500);
        @(negedge clk);
        check("midrst_idle_busy", busy, 0);
        check("midrst_no_ferr", ferr_cnt - f0, 0);
        check("midrst_no_valid", rise_cnt - r0, 0);
        tick(1);
        n0 = rxq.size();
        send(8'h5A, 1'b1, 1'b0);
        tick(20);
        @(negedge clk);
        check("midrst_next_count", rxq.size() - n0, 1);
        if (rxq.size() > n0) check("midrst_next_data", rxq[$], 8'h5A);
        tick(200);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit must be 1.
        p0 = perr_cnt;
        n0 = rxq.size();
        send(8'h07, 1'b1, 1'b1);
        tick(20);
        @(negedge clk);
        check("par_bad_pulse", perr_cnt - p0, 1);
        check("par_bad_no_valid", rxq.size() - n0, 0);
        tick(200);
        send(8'h07, 1'b1, 1'b0);
        tick(20);
        @(negedge clk);
        check("par_good_no_pulse", perr_cnt - p0, 1);
        check("par_good_count", rxq.size() - n0, 1);
        if (rxq.size() > n0) check("par_good_data", rxq[$], 8'h07);
        tick(200);
`else
        p0 = 0;
        check("noparity_tied_low", perr_cnt, 0);
`endif

        // Random frames: good stop delivers the byte, bad stop flags it.
        f0 = ferr_cnt;
        n0 = rxq.size();
        exp_ferr = p0 * 0;
        for (int k = 0; k < 12; k++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            send(b, ok, 1'b0);
            if (ok) expq.push_back(b);
            else exp_ferr++;
            if (ok) tick($urandom_range(0, 300));
            else tick(200 + $urandom_range(0, 100));
        end
        tick(20);
        @(negedge clk);
        check("rand_count", rxq.size() - n0, expq.size());
        check("rand_ferr", ferr_cnt - f0, exp_ferr);
        for (int j = 0; j < expq.size(); j++) begin
            if (n0 + j < rxq.size())
                check($sformatf("rand_byte%0d", j), rxq[n0 + j], expq[j]);
        end
        check("rand_no_overrun", ovr_cnt - o0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLK_HZ SHALL default to 12000000; it is the system clock frequency in Hz.
REQ-002 Parameter BAUD SHALL default to 115200; it is the serial bit rate.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single system clock; all logic is on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port uart_rx SHALL be an input, 1 bit wide: asynchronous serial line, idle high.
REQ-006 Port data_out SHALL be an output, 8 bits wide: the received byte.
REQ-007 Port data_valid SHALL be an output, 1 bit wide: data_out holds an unconsumed byte.
REQ-008 Port data_ready SHALL be an input, 1 bit wide: the consumer accepts the byte.
REQ-009 Port frame_err SHALL be an output, 1 bit wide: 1-cycle pulse on a bad stop bit.
REQ-010 Port overrun SHALL be an output, 1 bit wide: 1-cycle pulse when a completed byte is dropped.
REQ-011 Port parity_err SHALL be an output, 1 bit wide: 1-cycle pulse on a parity mismatch.
REQ-012 Port busy SHALL be an output, 1 bit wide: high while a frame is in progress.

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer before any use; frame timing is measured from the synchronized signal.
REQ-014 CLKS_PER_BIT SHALL equal CLK_HZ/BAUD (integer division); the bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide.
REQ-015 The states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP; busy SHALL be high in every state except IDLE.
REQ-016 In IDLE, a synchronized 0 SHALL move the block to START and clear the bit counter.
REQ-017 START SHALL sample the line at count CLKS_PER_BIT/2-1: a 0 moves to DATA; a 1 returns to IDLE as a glitch, with no error output.
REQ-018 DATA SHALL sample every CLKS_PER_BIT clocks at mid-bit and shift bits in LSB-first; after the 8th bit it moves to PARITY (if enabled) or STOP.
REQ-019 STOP SHALL sample at mid-bit and then return to IDLE in the next cycle, so back-to-back frames are accepted.
REQ-020 On a stop-bit sample of 1: if data_valid is 0 or data_ready is 1, data_out SHALL load the byte and data_valid SHALL be 1 on the next cycle.
REQ-021 On a stop-bit sample of 1 while data_valid is 1 and data_ready is 0: data_out SHALL keep the old byte and overrun SHALL pulse.
REQ-022 On a stop-bit sample of 0: frame_err SHALL pulse, the byte SHALL be discarded and data_valid SHALL be unchanged.
REQ-023 data_valid SHALL clear on the cycle after data_valid and data_ready are both 1, unless a new byte loads in that same cycle, in which case it SHALL stay 1.
REQ-024 data_out SHALL remain stable while data_valid is 1.

Reset
REQ-025 Reset SHALL clear state to IDLE, all counters to 0, data_out to 0x00, and data_valid, frame_err, overrun, parity_err and busy to 0.
REQ-026 Reset SHALL set both synchronizer flops to 1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no pulse output.

Configuration
REQ-028 With UART_RX_PARITY_EN defined, PARITY SHALL sample an even-parity bit at mid-bit before STOP.
REQ-029 With UART_RX_PARITY_EN defined, a parity mismatch SHALL pulse parity_err at the stop-bit sample and suppress the data_valid load.
REQ-030 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be tied to 0.

Structure
REQ-031 Package uart_pkg SHALL hold the rx state enum typedef, the DATA_BITS=8 constant, and the clocks-per-bit calculation function.
REQ-032 The synchronizer SHALL be a separate sub-module named uart_sync2, with clk, rst, async input and synchronized output.

Verification (CLK_HZ=12000000, BAUD=115200, so CLKS_PER_BIT=104)
REQ-033 Send 0xA5 8N1 with data_ready held at 1 -> data_out=0xA5, one data_valid pulse roughly 988 clocks after the start edge, and no error pulses.
REQ-034 Drive a 30-clock low glitch on uart_rx -> no data_valid and no frame_err; busy falls back to 0 within 55 clocks.
REQ-035 Send 0x3C with a stop bit of 0 -> frame_err pulses once and data_valid stays 0.
REQ-036 Send 0x11 then 0x22 back-to-back with data_ready held at 0 -> data_out stays 0x11, overrun pulses once at the second stop sample, and data_valid stays 1.
REQ-037 Assert rst during the 4th data bit of 0xFF, then send 0x5A -> all outputs read 0 after reset, then data_out=0x5A with data_valid.
REQ-038 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err pulses and there is no data_valid; 0x07 with parity bit 1 -> data_valid with data_out=0x07.
